// File: rtl/hdmi_vpg_window_if.sv
// ---------------------------------------------------------------------------
// hdmi_vpg_window_if
//
// Purpose: bundles the camera-buffer read port and the HDMI TX video bus
// used by hdmi_vpg_window.
//
// Signals:
//   rd_addr     buffer read address (ADDR_W bits)
//   rd_en       buffer read strobe
//   pixel       RGB565 read data, valid one clk after rd_en
//   pclk        pixel clock forwarded to the TX chip
//   hs, vs, de  raster timing
//   vga_r/g/b   RGB888 pixel
//   frame_start one-clk pulse on the first output clk of each frame
//
// Modports:
//   master  the pattern generator (drives addresses and video, reads pixel)
//   slave   the buffer / TX side (the mirror image of master)
// ---------------------------------------------------------------------------
interface hdmi_vpg_window_if #(
  parameter int ADDR_W = 15
);
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_en;
  logic [15:0]       pixel;
  logic              pclk;
  logic              hs;
  logic              vs;
  logic              de;
  logic [7:0]        vga_r;
  logic [7:0]        vga_g;
  logic [7:0]        vga_b;
  logic              frame_start;

  modport master (
    output rd_addr, rd_en, pclk, hs, vs, de, vga_r, vga_g, vga_b, frame_start,
    input  pixel
  );

  modport slave (
    input  rd_addr, rd_en, pclk, hs, vs, de, vga_r, vga_g, vga_b, frame_start,
    output pixel
  );
endinterface

// File: rtl/hdmi_vpg_window.sv
// ---------------------------------------------------------------------------
// hdmi_vpg_window
//
// Purpose: programmable HDMI raster generator. Produces hs/vs/de timing and
// RGB888 pixels; inside a placeable window of the active area it fetches
// RGB565 pixels from the camera buffer, with colour-bar, solid-colour and
// outlined-image modes as alternatives.
//
// Ports:
//   clk        pixel clock
//   rst        synchronous active-high reset
//   buffer_en  buffer holds valid data; first high clk starts the raster
//   mode       0 image, 1 colour bars, 2 solid BG_COLOR, 3 image + outline
//              (latched once per frame at h_count=0, v_count=0)
//   bus        hdmi_vpg_window_if.master: buffer read port + video outputs
//
// Pipeline: stage 0 decodes the counters, stage 1 issues the buffer read,
// stage 2 drives the outputs. Every output is two clks behind its decode.
// ---------------------------------------------------------------------------
module hdmi_vpg_window #(
  parameter int          H_TOTAL   = 800,
  parameter int          H_SYNC    = 96,
  parameter int          H_START   = 144,
  parameter int          H_ACT     = 640,
  parameter int          V_TOTAL   = 525,
  parameter int          V_SYNC    = 2,
  parameter int          V_START   = 35,
  parameter int          V_ACT     = 480,
  parameter bit          SYNC_POL  = 1'b0,
  parameter int          IMG_W     = 160,
  parameter int          IMG_H     = 120,
  parameter int          IMG_X     = 240,
  parameter int          IMG_Y     = 180,
  parameter int          ADDR_W    = 15,
  parameter logic [23:0] BG_COLOR  = 24'h000000,
  parameter logic [23:0] BOX_COLOR = 24'h00FFFF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                buffer_en,
  input  logic [1:0]          mode,
  hdmi_vpg_window_if.master   bus
);

  // One spare bit so that exclusive upper bounds equal to the total still fit.
  localparam int HW = $clog2(H_TOTAL + 1);
  localparam int VW = $clog2(V_TOTAL + 1);

  localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_SYNC_END = HW'(H_SYNC);
  localparam logic [HW-1:0] H_ACT_LO   = HW'(H_START);
  localparam logic [HW-1:0] H_ACT_HI   = HW'(H_START + H_ACT);
  localparam logic [HW-1:0] H_WIN_LO   = HW'(H_START + IMG_X);
  localparam logic [HW-1:0] H_WIN_LAST = HW'(H_START + IMG_X + IMG_W - 1);

  localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_SYNC_END = VW'(V_SYNC);
  localparam logic [VW-1:0] V_ACT_LO   = VW'(V_START);
  localparam logic [VW-1:0] V_ACT_HI   = VW'(V_START + V_ACT);
  localparam logic [VW-1:0] V_WIN_LO   = VW'(V_START + IMG_Y);
  localparam logic [VW-1:0] V_WIN_LAST = VW'(V_START + IMG_Y + IMG_H - 1);

  localparam logic [HW+2:0]     BAR_DIV   = (HW + 3)'(H_ACT);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(IMG_W * IMG_H - 1);

  typedef enum logic {ST_WAIT, ST_RUN} state_e;

  // Colour source chosen at decode time; the pixel itself only shows up at
  // the output stage.
  typedef enum logic [1:0] {SRC_BG, SRC_PIX, SRC_BOX, SRC_BAR} src_e;

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       de;
    logic       fs;
    src_e       src;
    logic [2:0] bar;
  } pipe_t;

  localparam pipe_t PIPE_IDLE = '{hs: ~SYNC_POL, vs: ~SYNC_POL, de: 1'b0,
                                  fs: 1'b0, src: SRC_BG, bar: 3'd0};

  state_e            state_q, state_d;
  logic              run;
  logic [HW-1:0]     h_count;
  logic [VW-1:0]     v_count;
  logic [1:0]        mode_q;
  logic              frame_top, act, win, perim;
  logic [HW-1:0]     ax;
  logic [2:0]        bar;
  src_e              src;
  pipe_t             d0, s1, s2;
  logic              rd_en_d, rd_en_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic [23:0]       rgb;
  logic [15:0]       p;

  assign run = (state_q == ST_RUN);

  // FSM next state. rst is handled in the state register, so it wins from
  // any state, mid-frame included.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    state_d = state_q;
    unique case (state_q)
      ST_WAIT: if (buffer_en) state_d = ST_RUN;
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_WAIT;
    endcase
  end

  // Stage-0 decode from the raster counters.
  always_comb begin
    frame_top = (h_count == '0) && (v_count == '0);
    act   = (h_count >= H_ACT_LO) && (h_count < H_ACT_HI) &&
            (v_count >= V_ACT_LO) && (v_count < V_ACT_HI);
    win   = act && (h_count >= H_WIN_LO) && (h_count <= H_WIN_LAST) &&
                   (v_count >= V_WIN_LO) && (v_count <= V_WIN_LAST);
    perim = (h_count == H_WIN_LO) || (h_count == H_WIN_LAST) ||
            (v_count == V_WIN_LO) || (v_count == V_WIN_LAST);
    ax    = h_count - H_ACT_LO;
    // Only meaningful while act is set, where ax < H_ACT keeps it in 0..7.
    bar   = 3'({ax, 3'b000} / BAR_DIV);

    src = SRC_BG;
    unique case (mode_q)
      2'd0:    src = win ? SRC_PIX : SRC_BG;
      2'd1:    src = SRC_BAR;
      2'd2:    src = SRC_BG;
      default: src = win ? (perim ? SRC_BOX : SRC_PIX) : SRC_BG;
    endcase

    d0 = PIPE_IDLE;
    if (run) begin
      d0.hs  = (h_count < H_SYNC_END) ? SYNC_POL : ~SYNC_POL;
      d0.vs  = (v_count < V_SYNC_END) ? SYNC_POL : ~SYNC_POL;
      d0.de  = act;
      d0.fs  = frame_top;
      d0.src = src;
      d0.bar = bar;
    end

    // Perimeter pixels in mode 3 are still read so the address sequence
    // does not depend on the mode's overlay.
    rd_en_d = run && win && ((mode_q == 2'd0) || (mode_q == 2'd3));
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    if (rst) begin
      state_q   <= ST_WAIT;
      h_count   <= '0;
      v_count   <= '0;
      mode_q    <= 2'd0;
      s1        <= PIPE_IDLE;
      s2        <= PIPE_IDLE;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
    end else begin
      state_q <= state_d;

      if (run) begin
        if (h_count == H_LAST) begin
          h_count <= '0;
          v_count <= (v_count == V_LAST) ? '0 : v_count + VW'(1);
        end else begin
          h_count <= h_count + HW'(1);
        end
      end else begin
        h_count <= '0;
        v_count <= '0;
      end

      // The first active line is well past the frame top, so every pixel
      // of a frame sees the mode latched here.
      if (run && frame_top) mode_q <= mode;

      s1      <= d0;
      s2      <= s1;
      rd_en_q <= rd_en_d;

      if (!run || frame_top) begin
        rd_addr_q <= '0;
      end else if (rd_en_q) begin
        rd_addr_q <= (rd_addr_q == ADDR_LAST) ? '0 : rd_addr_q + ADDR_W'(1);
      end
    end
  end

  // The buffer answers one clk after the stage-1 read, i.e. in the same clk
  // as the output stage, so the colour mux after s2 is combinational on
  // pixel while all timing and selection stays registered.
  assign p = bus.pixel;

  always_comb begin
    rgb = 24'h000000;
    if (s2.de) begin
      unique case (s2.src)
        SRC_PIX: rgb = {p[15:11], p[15:13], p[10:5], p[10:9], p[4:0], p[4:2]};
        SRC_BOX: rgb = BOX_COLOR;
        // Bar order white, yellow, cyan, green, magenta, red, blue, black
        // maps to r = ~bar[1], g = ~bar[2], b = ~bar[0].
        SRC_BAR: rgb = {{8{~s2.bar[1]}}, {8{~s2.bar[2]}}, {8{~s2.bar[0]}}};
        default: rgb = BG_COLOR;
      endcase
    end
  end

  assign bus.pclk        = clk;
  assign bus.rd_en       = rd_en_q;
  assign bus.rd_addr     = rd_addr_q;
  assign bus.hs          = s2.hs;
  assign bus.vs          = s2.vs;
  assign bus.de          = s2.de;
  assign bus.frame_start = s2.fs;
  assign bus.vga_r       = rgb[23:16];
  assign bus.vga_g       = rgb[15:8];
  assign bus.vga_b       = rgb[7:0];

endmodule

// File: tb/tb_hdmi_vpg_window.sv
// ---------------------------------------------------------------------------
// tb_hdmi_vpg_window
//
// Directed bench for hdmi_vpg_window on a 20x10 raster with a 4x3 window at
// (2,1) inside a 12x6 active area. The buffer model returns mem[rd_addr] one
// clk after rd_en. Cycle index c counts clks since the raster started;
// outputs at c describe counter position c-2, the read for position p is
// visible at c=p+1.
// ---------------------------------------------------------------------------
module tb_hdmi_vpg_window;

  localparam logic [23:0] BG  = 24'h102030;
  localparam logic [23:0] BOX = 24'h00FFFF;

  logic       clk = 1'b0;
  logic       rst;
  logic       buffer_en;
  logic [1:0] mode;

  hdmi_vpg_window_if #(.ADDR_W(4)) bus ();

  hdmi_vpg_window #(
    .H_TOTAL(20), .H_SYNC(2), .H_START(4), .H_ACT(12),
    .V_TOTAL(10), .V_SYNC(1), .V_START(2), .V_ACT(6),
    .SYNC_POL(1'b0),
    .IMG_W(4), .IMG_H(3), .IMG_X(2), .IMG_Y(1),
    .ADDR_W(4), .BG_COLOR(BG), .BOX_COLOR(BOX)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .buffer_en (buffer_en),
    .mode      (mode),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  // Buffer model.
  logic [15:0] mem [16];
  always @(posedge clk) if (bus.rd_en) bus.pixel <= mem[bus.rd_addr];

  // Cumulative monitors; the stimulus takes snapshots and checks deltas.
  int de_cnt = 0, hs_lo = 0, vs_lo = 0, fs_cnt = 0;
  always @(negedge clk) begin
    if (bus.de)          de_cnt++;
    if (!bus.hs)         hs_lo++;
    if (!bus.vs)         vs_lo++;
    if (bus.frame_start) fs_cnt++;
  end

  logic [3:0] rd_log [$];
  always @(posedge clk) if (bus.rd_en) rd_log.push_back(bus.rd_addr);

  int tests = 0, fails = 0;
  int c = 0;
  int b_de, b_hs, b_vs, b_fs, b_rd;

  task automatic tick();
    @(posedge clk);
    #1;
    c++;
  endtask

  task automatic goto_c(input int t);
    while (c < t) tick();
  endtask

  function automatic logic [23:0] rgb();
    return {bus.vga_r, bus.vga_g, bus.vga_b};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_hs"},      32'(bus.hs), 32'd1);
    check({tag, "_vs"},      32'(bus.vs), 32'd1);
    check({tag, "_de"},      32'(bus.de), 32'd0);
    check({tag, "_fs"},      32'(bus.frame_start), 32'd0);
    check({tag, "_rgb"},     32'(rgb()), 32'd0);
    check({tag, "_rd_en"},   32'(bus.rd_en), 32'd0);
    check({tag, "_rd_addr"}, 32'(bus.rd_addr), 32'd0);
  endtask

  task automatic snapshot();
    b_de = de_cnt; b_hs = hs_lo; b_vs = vs_lo; b_fs = fs_cnt; b_rd = rd_log.size();
  endtask

  task automatic check_reads(input string tag, input int n_exp);
    int n, bad;
    n   = rd_log.size() - b_rd;
    bad = 0;
    for (int k = 0; k < n; k++) if (rd_log[b_rd + k] !== 4'(k)) bad++;
    check({tag, "_rd_count"}, 32'(n), 32'(n_exp));
    check({tag, "_rd_seq"},   32'(bad), 32'd0);
  endtask

  task automatic idle_for(input string tag, input int n);
    int bad;
    bad = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (bus.hs !== 1'b1 || bus.vs !== 1'b1 || bus.de !== 1'b0 ||
          bus.frame_start !== 1'b0 || rgb() !== 24'h0 || bus.rd_en !== 1'b0)
        bad++;
    end
    check(tag, 32'(bad), 32'd0);
  endtask

  task automatic start();
    buffer_en = 1'b1;
    tick();
    buffer_en = 1'b0;
    c = 0;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 16'(i);
    rst = 1'b1; buffer_en = 1'b0; mode = 2'd0;
    repeat (3) tick();
    rst = 1'b0;
    check_idle("reset");
    check("pclk", 32'(bus.pclk), 32'(clk));

    // Gated start, then a single-clk buffer_en pulse.
    idle_for("idle_before_start", 1000);
    start();

    // Frame 0, mode 0.
    goto_c(2);
    check("f0_fs", 32'(bus.frame_start), 32'd1);
    check("f0_hs0", 32'(bus.hs), 32'd0);
    check("f0_vs0", 32'(bus.vs), 32'd0);
    check("f0_de0", 32'(bus.de), 32'd0);
    snapshot();
    goto_c(3);
    check("f0_fs_pulse", 32'(bus.frame_start), 32'd0);
    check("f0_hs1", 32'(bus.hs), 32'd0);
    goto_c(4);
    check("f0_hs2", 32'(bus.hs), 32'd1);
    goto_c(21);
    check("f0_vs_end", 32'(bus.vs), 32'd0);
    goto_c(22);
    check("f0_vs_off", 32'(bus.vs), 32'd1);
    goto_c(46);
    check("f0_act_de", 32'(bus.de), 32'd1);
    check("f0_act_bg", 32'(rgb()), 32'(BG));
    goto_c(60);
    mode = 2'd1;  // must not take effect until frame 1
    goto_c(67);
    check("f0_rd_first_en", 32'(bus.rd_en), 32'd1);
    check("f0_rd_first_addr", 32'(bus.rd_addr), 32'd0);
    goto_c(85);
    check("f0_porch_de", 32'(bus.de), 32'd0);
    check("f0_porch_rgb", 32'(rgb()), 32'd0);
    goto_c(87);
    check("f0_nonwin_bg", 32'(rgb()), 32'(BG));
    goto_c(88);
    check("f0_rd5_en", 32'(bus.rd_en), 32'd1);
    check("f0_rd5_addr", 32'(bus.rd_addr), 32'd5);
    goto_c(89);
    check("f0_pix5", 32'(rgb()), 32'h000029);
    goto_c(202);
    check("f0_de_count", 32'(de_cnt - b_de), 32'd72);
    check("f0_hs_low", 32'(hs_lo - b_hs), 32'd20);
    check("f0_vs_low", 32'(vs_lo - b_vs), 32'd20);
    check("f0_fs_count", 32'(fs_cnt - b_fs), 32'd1);
    check_reads("f0", 12);
    check("f1_fs", 32'(bus.frame_start), 32'd1);
    snapshot();

    // Frame 1, colour bars (row v=2, ax = h-4).
    goto_c(246); check("f1_bar_white",   32'(rgb()), 32'hFFFFFF);
    goto_c(248); check("f1_bar_yellow",  32'(rgb()), 32'hFFFF00);
    goto_c(249); check("f1_bar_cyan",    32'(rgb()), 32'h00FFFF);
    goto_c(255); check("f1_bar_blue",    32'(rgb()), 32'h0000FF);
    goto_c(257);
    check("f1_bar_black", 32'(rgb()), 32'h000000);
    check("f1_bar_black_de", 32'(bus.de), 32'd1);
    goto_c(260);
    mode = 2'd3;
    goto_c(267);
    check("f1_no_read", 32'(bus.rd_en), 32'd0);
    goto_c(292);
    check("f1_bar_magenta_after_change", 32'(rgb()), 32'hFF00FF);
    goto_c(402);
    check_reads("f1", 0);
    snapshot();
    mem[5] = 16'hF800;
    mem[6] = 16'h07E0;

    // Frame 2, image + outline.
    goto_c(467);
    check("f2_rd_restart_en", 32'(bus.rd_en), 32'd1);
    check("f2_rd_restart_addr", 32'(bus.rd_addr), 32'd0);
    goto_c(468); check("f2_box_corner", 32'(rgb()), 32'(BOX));
    goto_c(488); check("f2_box_left",   32'(rgb()), 32'(BOX));
    goto_c(489); check("f2_pix_red",    32'(rgb()), 32'hFF0000);
    goto_c(490); check("f2_pix_green",  32'(rgb()), 32'h00FF00);
    goto_c(491); check("f2_box_right",  32'(rgb()), 32'(BOX));
    goto_c(492); check("f2_outside_bg", 32'(rgb()), 32'(BG));
    goto_c(500);
    mode = 2'd0;
    mem[0] = 16'hFFFF;
    goto_c(602);
    check_reads("f2", 12);

    // Frame 3, mode 0 again, then reset on line 5.
    goto_c(668); check("f3_pix_white", 32'(rgb()), 32'hFFFFFF);
    goto_c(671); check("f3_pix3",      32'(rgb()), 32'h000018);
    goto_c(689); check("f3_pix_red",   32'(rgb()), 32'hFF0000);
    goto_c(702);
    check("f3_addr_before_rst", 32'(bus.rd_addr), 32'd8);
    rst = 1'b1;
    tick();
    check_idle("midframe_rst");
    rst = 1'b0;
    idle_for("idle_after_rst", 50);
    start();
    goto_c(2);
    check("restart_fs", 32'(bus.frame_start), 32'd1);
    goto_c(67);
    check("restart_rd_en", 32'(bus.rd_en), 32'd1);
    check("restart_rd_addr", 32'(bus.rd_addr), 32'd0);
    goto_c(68);
    check("restart_pix", 32'(rgb()), 32'hFFFFFF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
